sprite_line_sched: RTL and testbench

// Per-line scheduler that shares a small pool of sprite engines between NSPR sprites.
// On each line pulse it scans a descriptor table, selects up to SLOTS sprites covering that line, and

---
 rtl/sprite_line_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_sprite_line_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_sched.sv
// sprite_line_sched: per-line scheduler assigning up to SLOTS covering sprites
// from a double-buffered descriptor table to sprite engine slots.
module sprite_line_sched #(
  parameter  int CORDW      = 16,
  parameter  int NSPR       = 8,
  parameter  int SLOTS      = 2,
  parameter  int SPR_HEIGHT = 8,
  parameter  int SPR_SCALE  = 4,
  localparam int IDW        = $clog2(NSPR)
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix_n,
  input  logic                   frame,
  input  logic                   line,
  input  logic [CORDW-1:0]       sy,
  input  logic                   cfg_we,
  input  logic [IDW-1:0]         cfg_idx,
  input  logic                   cfg_en,
  input  logic [CORDW-1:0]       cfg_x,
  input  logic [CORDW-1:0]       cfg_y,
  output logic                   slot_start,
  output logic [SLOTS-1:0]       slot_valid,
  output logic [SLOTS*IDW-1:0]   slot_id,
  output logic [SLOTS*CORDW-1:0] slot_x,
  output logic [SLOTS*CORDW-1:0] slot_y,
  output logic                   overflow,
  output logic [7:0]             ovf_count,
  output logic                   late_err
);

  localparam int CW = $clog2(SLOTS + 2);
  localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
  localparam logic signed [CORDW:0] SH_E = (CORDW+1)'(SPR_HEIGHT << SPR_SCALE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_n;
  logic   start_scan, scan_last, commit, late_line, pending;

  logic             sh_en  [NSPR];
  logic [CORDW-1:0] sh_x   [NSPR];
  logic [CORDW-1:0] sh_y   [NSPR];
  logic             act_en [NSPR];
  logic [CORDW-1:0] act_x  [NSPR];
  logic [CORDW-1:0] act_y  [NSPR];

  logic [IDW-1:0]   idx;
  logic [CORDW-1:0] ly;
  logic [CW-1:0]    cnt, cnt_n;
  logic [SLOTS-1:0] stg_valid, stg_valid_n;
  logic [IDW-1:0]   stg_id   [SLOTS];
  logic [IDW-1:0]   stg_id_n [SLOTS];
  logic [CORDW-1:0] stg_x    [SLOTS];
  logic [CORDW-1:0] stg_x_n  [SLOTS];
  logic [CORDW-1:0] stg_y    [SLOTS];
  logic [CORDW-1:0] stg_y_n  [SLOTS];

  logic signed [CORDW:0] ly_e, y_e, y_end;
  logic                  hit;

  // State register.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) state <= IDLE;
    else            state <= state_n;
  end

  // Next-state and control decode; a deferred commit lands on the DONE->IDLE edge.
  always_comb begin
    state_n    = state;
    start_scan = 1'b0;
    scan_last  = 1'b0;
    commit     = 1'b0;
    late_line  = 1'b0;
    case (state)
      IDLE: begin
        commit = frame;
        if (line) begin
          start_scan = 1'b1;
          state_n    = SCAN;
        end
      end
      SCAN: begin
        late_line = line;
        if (idx == IDW'(NSPR - 1)) begin
          scan_last = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        late_line = line;
        commit    = frame | pending;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Coverage test in CORDW+1 signed bits so y+SH never wraps.
  always_comb begin
    ly_e  = {ly[CORDW-1], ly};
    y_e   = {act_y[idx][CORDW-1], act_y[idx]};
    y_end = y_e + SH_E;
    hit   = act_en[idx] && (ly_e >= y_e) && (ly_e < y_end);
  end

  // Staged slot fill for the descriptor currently being scanned.
  always_comb begin
    stg_valid_n = stg_valid;
    cnt_n       = cnt;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      stg_id_n[s] = stg_id[s];
      stg_x_n[s]  = stg_x[s];
      stg_y_n[s]  = stg_y[s];
    end
    if (state == SCAN && hit) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        if (cnt == CW'(s)) begin
          stg_valid_n[s] = 1'b1;
          stg_id_n[s]    = idx;
          stg_x_n[s]     = act_x[idx];
          stg_y_n[s]     = act_y[idx];
        end
      end
      if (cnt <= SLOTS_C) cnt_n = cnt + CW'(1);
    end
  end

  // Shadow writes in any state; commit copies the pre-write shadow.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int unsigned i = 0; i < NSPR; i++) begin
        sh_en[i]  <= 1'b0;
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        act_en[i] <= 1'b0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
      end
    end else begin
      if (commit) begin
        for (int unsigned i = 0; i < NSPR; i++) begin
          act_en[i] <= sh_en[i];
          act_x[i]  <= sh_x[i];
          act_y[i]  <= sh_y[i];
        end
      end
      if (cfg_we) begin
        sh_en[cfg_idx] <= cfg_en;
        sh_x[cfg_idx]  <= cfg_x;
        sh_y[cfg_idx]  <= cfg_y;
      end
    end
  end

  // Scan index, captured line and staged slot registers.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      idx       <= '0;
      ly        <= '0;
      cnt       <= '0;
      stg_valid <= '0;
      for (int unsigned s = 0; s < SLOTS; s++) begin
        stg_id[s] <= '0;
        stg_x[s]  <= '0;
        stg_y[s]  <= '0;
      end
    end else if (start_scan) begin
      idx       <= '0;
      ly        <= sy;
      cnt       <= '0;
      stg_valid <= '0;
      for (int unsigned s = 0; s < SLOTS; s++) begin
        stg_id[s] <= '0;
        stg_x[s]  <= '0;
        stg_y[s]  <= '0;
      end
    end else if (state == SCAN) begin
      idx       <= idx + IDW'(1);
      cnt       <= cnt_n;
      stg_valid <= stg_valid_n;
      for (int unsigned s = 0; s < SLOTS; s++) begin
        stg_id[s] <= stg_id_n[s];
        stg_x[s]  <= stg_x_n[s];
        stg_y[s]  <= stg_y_n[s];
      end
    end
  end

  // Slot outputs load from the final staged values on the last scan edge,
  // so they are valid together with slot_start during DONE.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      slot_start <= 1'b0;
      overflow   <= 1'b0;
      slot_valid <= '0;
      slot_id    <= '0;
      slot_x     <= '0;
      slot_y     <= '0;
    end else begin
      slot_start <= scan_last;
      overflow   <= scan_last && (cnt_n > SLOTS_C);
      if (scan_last) begin
        slot_valid <= stg_valid_n;
        for (int unsigned s = 0; s < SLOTS; s++) begin
          slot_id[s*IDW +: IDW]     <= stg_id_n[s];
          slot_x[s*CORDW +: CORDW]  <= stg_x_n[s];
          slot_y[s*CORDW +: CORDW]  <= stg_y_n[s];
        end
      end
    end
  end

  // Pending commit, overflow counter and sticky late-line flag.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pending   <= 1'b0;
      ovf_count <= '0;
      late_err  <= 1'b0;
    end else begin
      if (commit)     pending <= 1'b0;
      else if (frame) pending <= 1'b1;
      if (commit)
        ovf_count <= '0;
      else if (scan_last && (cnt_n > SLOTS_C) && ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'd1;
      if (late_line) late_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_line_sched.sv
// tb_sprite_line_sched: directed and randomized checks against a table-level model.
module tb_sprite_line_sched;

  localparam int CORDW = 16;
  localparam int NSPR  = 8;
  localparam int SLOTS = 2;
  localparam int IDW   = 3;
  localparam int SH    = 8 << 4;

  logic                   clk_pix = 1'b0;
  logic                   rst_pix_n = 1'b0;
  logic                   frame = 1'b0;
  logic                   line = 1'b0;
  logic [CORDW-1:0]       sy = '0;
  logic                   cfg_we = 1'b0;
  logic [IDW-1:0]         cfg_idx = '0;
  logic                   cfg_en = 1'b0;
  logic [CORDW-1:0]       cfg_x = '0;
  logic [CORDW-1:0]       cfg_y = '0;
  logic                   slot_start;
  logic [SLOTS-1:0]       slot_valid;
  logic [SLOTS*IDW-1:0]   slot_id;
  logic [SLOTS*CORDW-1:0] slot_x;
  logic [SLOTS*CORDW-1:0] slot_y;
  logic                   overflow;
  logic [7:0]             ovf_count;
  logic                   late_err;

  sprite_line_sched #(
    .CORDW(CORDW), .NSPR(NSPR), .SLOTS(SLOTS), .SPR_HEIGHT(8), .SPR_SCALE(4)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .line(line), .sy(sy),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .slot_start(slot_start), .slot_valid(slot_valid), .slot_id(slot_id),
    .slot_x(slot_x), .slot_y(slot_y), .overflow(overflow), .ovf_count(ovf_count),
    .late_err(late_err)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: descriptor tables as plain integers.
  int m_sh_en [NSPR];
  int m_sh_x  [NSPR];
  int m_sh_y  [NSPR];
  int m_act_en[NSPR];
  int m_act_x [NSPR];
  int m_act_y [NSPR];
  int m_ovf  = 0;
  int m_late = 0;
  int m_pend = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NSPR; i++) begin
      m_sh_en[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0;
      m_act_en[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0;
    end
    m_ovf = 0; m_late = 0; m_pend = 0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < NSPR; i++) begin
      m_act_en[i] = m_sh_en[i];
      m_act_x[i]  = m_sh_x[i];
      m_act_y[i]  = m_sh_y[i];
    end
    m_ovf = 0;
  endtask

  task automatic wr(input int idx, input int en, input int x, input int y);
    cfg_we = 1'b1; cfg_idx = IDW'(idx); cfg_en = en[0];
    cfg_x = CORDW'(x); cfg_y = CORDW'(y);
    tick();
    cfg_we = 1'b0;
    m_sh_en[idx] = en; m_sh_x[idx] = x; m_sh_y[idx] = y;
  endtask

  task automatic do_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    model_commit();
  endtask

  task automatic frame_with_write(input int idx, input int en, input int x, input int y);
    frame = 1'b1;
    cfg_we = 1'b1; cfg_idx = IDW'(idx); cfg_en = en[0];
    cfg_x = CORDW'(x); cfg_y = CORDW'(y);
    tick();
    frame = 1'b0; cfg_we = 1'b0;
    model_commit();
    m_sh_en[idx] = en; m_sh_x[idx] = x; m_sh_y[idx] = y;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"},  64'(slot_start), 64'(0));
    check({tag, "_valid"},  64'(slot_valid), 64'(0));
    check({tag, "_id"},     64'(slot_id),    64'(0));
    check({tag, "_x"},      64'(slot_x),     64'(0));
    check({tag, "_y"},      64'(slot_y),     64'(0));
    check({tag, "_ovf"},    64'(overflow),   64'(0));
    check({tag, "_ovfcnt"}, 64'(ovf_count),  64'(0));
    check({tag, "_late"},   64'(late_err),   64'(0));
  endtask

  // One line: optional late second line pulse and/or frame pulse during the scan.
  task automatic run_line(input int sy_v, input bit late, input bit fmid);
    int hits[$];
    logic [SLOTS-1:0]       ev;
    logic [SLOTS*IDW-1:0]   eid;
    logic [SLOTS*CORDW-1:0] ex, ey;
    logic                   eovf;
    int c0;
    for (int i = 0; i < NSPR; i++)
      if (m_act_en[i] != 0 && sy_v >= m_act_y[i] && sy_v < m_act_y[i] + SH)
        hits.push_back(i);
    ev = '0; eid = '0; ex = '0; ey = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (s < hits.size()) begin
        ev[s] = 1'b1;
        eid[s*IDW +: IDW]    = IDW'(hits[s]);
        ex[s*CORDW +: CORDW] = CORDW'(m_act_x[hits[s]]);
        ey[s*CORDW +: CORDW] = CORDW'(m_act_y[hits[s]]);
      end
    end
    eovf = (hits.size() > SLOTS);

    line = 1'b1; sy = CORDW'(sy_v);
    c0 = cyc;
    tick();
    line = 1'b0;
    for (int k = 0; k < 30 && !slot_start; k++) begin
      if (k == 2) begin
        line  = late;
        frame = fmid;
      end
      tick();
      line = 1'b0; frame = 1'b0;
    end
    check("start_seen", 64'(slot_start), 64'(1));
    check("latency", 64'(cyc - c0), 64'(NSPR + 1));
    check("valid", 64'(slot_valid), 64'(ev));
    check("id",    64'(slot_id),    64'(eid));
    check("x",     64'(slot_x),     64'(ex));
    check("y",     64'(slot_y),     64'(ey));
    check("overflow", 64'(overflow), 64'(eovf));
    if (eovf && m_ovf < 255) m_ovf++;
    if (late) m_late = 1;
    if (fmid) m_pend = 1;
    check("ovf_count", 64'(ovf_count), 64'(m_ovf));
    check("late_err",  64'(late_err),  64'(m_late));
    tick();
    if (m_pend != 0) begin
      model_commit();
      m_pend = 0;
    end
    check("start_pulse", 64'(slot_start), 64'(0));
    check("ovf_pulse",   64'(overflow),   64'(0));
    check("valid_hold",  64'(slot_valid), 64'(ev));
    check("ovf_after",   64'(ovf_count),  64'(m_ovf));
  endtask

  initial begin
    model_clear();
    #12;
    check_zero("reset");
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    tick();

    // Basic schedule and latency.
    wr(0, 1, 32, 16);
    do_frame();
    run_line(16, 0, 0);

    // Vertical coverage boundaries, negative y, no wrap near the top of range.
    run_line(15, 0, 0);
    run_line(143, 0, 0);
    run_line(144, 0, 0);
    wr(0, 1, 32, -100);
    do_frame();
    run_line(27, 0, 0);
    run_line(28, 0, 0);
    wr(0, 1, 5, 32700);
    do_frame();
    run_line(-32000, 0, 0);
    run_line(32767, 0, 0);
    wr(0, 0, 0, 0);

    // Overflow and its clear on the next frame.
    wr(1, 1, 100, 0);
    wr(3, 1, 200, 10);
    wr(6, 1, 300, 50);
    do_frame();
    run_line(50, 0, 0);
    do_frame();
    check("ovf_cleared", 64'(ovf_count), 64'(m_ovf));

    // Shadow/active separation and write racing a frame.
    wr(1, 0, 0, 0);
    wr(3, 0, 0, 0);
    do_frame();
    wr(2, 1, 77, 40);
    run_line(40, 0, 0);
    do_frame();
    run_line(40, 0, 0);
    frame_with_write(2, 1, 88, 300);
    run_line(40, 0, 0);
    do_frame();
    run_line(40, 0, 0);
    run_line(300, 0, 0);

    // Late line pulse, then a frame during scan.
    run_line(300, 1, 0);
    wr(2, 1, 99, 60);
    run_line(60, 0, 1);
    run_line(60, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++)
        wr(int'($urandom_range(0, NSPR - 1)), int'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 400)) - 200);
      if ($urandom_range(0, 1) != 0) do_frame();
      run_line(int'($urandom_range(0, 300)) - 50,
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a scan.
    wr(1, 1, 11, 0);
    wr(3, 1, 33, 0);
    wr(6, 1, 66, 0);
    do_frame();
    run_line(50, 0, 0);
    line = 1'b1; sy = CORDW'(50);
    tick();
    line = 1'b0;
    tick();
    tick();
    rst_pix_n = 1'b0;
    #1;
    model_clear();
    check_zero("midscan_rst");
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    tick();
    run_line(50, 0, 0);
    do_frame();
    run_line(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
